regfile_ctx_engine: RTL and testbench

Context save/restore engine that drives the control side of the 8-entry register file (R1–R4, S1–S4). A save command reads a masked subset of registers through the file's OutA port and streams each value out over a valid/ready port. A restore command accepts a stream of words and writes each one back into the file with a FunSel=010 (load) write. It sits between the control unit and the register file and owns the file's write enables and OutASel while busy.

---
 rtl/regfile_ctx_engine.sv | 205 ++++++++++++++++++++
 tb/tb_regfile_ctx_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine for the 8-entry register file (R1-R4, S1-S4).
// Streams a masked subset of registers out on save and writes a word stream back on restore.
module regfile_ctx_engine #(
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    input  logic              CmdOp,
    input  logic [7:0]        CmdMask,
    output logic              CmdReady,
    output logic [2:0]        RfOutASel,
    input  logic [DATA_W-1:0] RfOutA,
    output logic [DATA_W-1:0] RfI,
    output logic [2:0]        RfFunSel,
    output logic [3:0]        RfRegSel,
    output logic [3:0]        RfScrSel,
    output logic [DATA_W-1:0] SaveData,
    output logic [2:0]        SaveIdx,
    output logic              SaveValid,
    input  logic              SaveReady,
    input  logic [DATA_W-1:0] RestData,
    input  logic              RestValid,
    output logic              RestReady,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SAVE_RD   = 3'd1,
        SAVE_OUT  = 3'd2,
        REST_WAIT = 3'd3,
        REST_WR   = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Index of the lowest set bit; zero when the mask is empty.
    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r = i[2:0];
            end
        end
        return r;
    endfunction

    // Write enable for one index as {RegSel, ScrSel}: index 0 (R1) is the MSB.
    function automatic logic [7:0] we_onehot(input logic [2:0] idx);
        return 8'h80 >> idx;
    endfunction

    state_t            state_r;
    logic [7:0]        mask_r;
    logic [2:0]        idx_r;
    logic              cmd_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              save_valid_r;
    logic              rest_ready_r;
    logic [3:0]        reg_sel_r;
    logic [3:0]        scr_sel_r;
    logic [2:0]        out_a_sel_r;
    logic [DATA_W-1:0] rf_i_r;
    logic [DATA_W-1:0] save_data_r;
    logic [2:0]        save_idx_r;

    logic [7:0]        rest_mask_s;
    logic              has_next_s;
    logic [2:0]        next_idx_s;
    logic [2:0]        first_idx_s;

    // Remaining work once the current index is retired, and where a new command starts.
    always_comb begin
        rest_mask_s = 8'h00;
        has_next_s  = 1'b0;
        next_idx_s  = 3'd0;
        first_idx_s = 3'd0;
        rest_mask_s = mask_r & ~(8'h01 << idx_r);
        has_next_s  = |rest_mask_s;
        next_idx_s  = lowest_idx(rest_mask_s);
        first_idx_s = lowest_idx(CmdMask);
    end

    // Command FSM; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r      <= IDLE;
            mask_r       <= 8'h00;
            idx_r        <= 3'd0;
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            save_valid_r <= 1'b0;
            rest_ready_r <= 1'b0;
            reg_sel_r    <= 4'b0000;
            scr_sel_r    <= 4'b0000;
            out_a_sel_r  <= 3'd0;
            rf_i_r       <= '0;
            save_data_r  <= '0;
            save_idx_r   <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (CmdValid) begin
                        mask_r      <= CmdMask;
                        idx_r       <= first_idx_s;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (CmdMask == 8'h00) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else if (CmdOp == 1'b0) begin
                            state_r     <= SAVE_RD;
                            out_a_sel_r <= first_idx_s;
                        end else begin
                            state_r      <= REST_WAIT;
                            rest_ready_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SAVE_RD: begin
                    save_data_r  <= RfOutA;
                    save_idx_r   <= idx_r;
                    save_valid_r <= 1'b1;
                    state_r      <= SAVE_OUT;
                end
                SAVE_OUT: begin
                    if (SaveReady) begin
                        save_valid_r <= 1'b0;
                        mask_r       <= rest_mask_s;
                        if (has_next_s) begin
                            idx_r       <= next_idx_s;
                            out_a_sel_r <= next_idx_s;
                            state_r     <= SAVE_RD;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= SAVE_OUT;
                    end
                end
                REST_WAIT: begin
                    if (RestValid) begin
                        rf_i_r                 <= RestData;
                        rest_ready_r           <= 1'b0;
                        {reg_sel_r, scr_sel_r} <= we_onehot(idx_r);
                        state_r                <= REST_WR;
                    end else begin
                        state_r <= REST_WAIT;
                    end
                end
                REST_WR: begin
                    // The enable set on entry commits at this edge; drop it immediately.
                    reg_sel_r <= 4'b0000;
                    scr_sel_r <= 4'b0000;
                    mask_r    <= rest_mask_s;
                    if (has_next_s) begin
                        idx_r        <= next_idx_s;
                        rest_ready_r <= 1'b1;
                        state_r      <= REST_WAIT;
                    end else begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    cmd_ready_r  <= 1'b1;
                    save_valid_r <= 1'b0;
                    rest_ready_r <= 1'b0;
                    reg_sel_r    <= 4'b0000;
                    scr_sel_r    <= 4'b0000;
                end
            endcase
        end
    end

    assign CmdReady  = cmd_ready_r;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign SaveValid = save_valid_r;
    assign SaveData  = save_data_r;
    assign SaveIdx   = save_idx_r;
    assign RestReady = rest_ready_r;
    assign RfOutASel = out_a_sel_r;
    assign RfI       = rf_i_r;
    assign RfRegSel  = reg_sel_r;
    assign RfScrSel  = scr_sel_r;
    assign RfFunSel  = 3'b010;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Table-driven bench for regfile_ctx_engine with a behavioural 8-entry register file.
module tb_regfile_ctx_engine;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        CmdValid;
    logic        CmdOp;
    logic [7:0]  CmdMask;
    logic        CmdReady;
    logic [2:0]  RfOutASel;
    logic [31:0] RfOutA;
    logic [31:0] RfI;
    logic [2:0]  RfFunSel;
    logic [3:0]  RfRegSel;
    logic [3:0]  RfScrSel;
    logic [31:0] SaveData;
    logic [2:0]  SaveIdx;
    logic        SaveValid;
    logic        SaveReady;
    logic [31:0] RestData;
    logic        RestValid;
    logic        RestReady;
    logic        Busy;
    logic        Done;

    regfile_ctx_engine #(.DATA_W(32)) dut (
        .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdOp(CmdOp), .CmdMask(CmdMask),
        .CmdReady(CmdReady), .RfOutASel(RfOutASel), .RfOutA(RfOutA), .RfI(RfI),
        .RfFunSel(RfFunSel), .RfRegSel(RfRegSel), .RfScrSel(RfScrSel), .SaveData(SaveData),
        .SaveIdx(SaveIdx), .SaveValid(SaveValid), .SaveReady(SaveReady), .RestData(RestData),
        .RestValid(RestValid), .RestReady(RestReady), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // Register file model: load (FunSel 010) with {RegSel,ScrSel} enables, MSB = R1.
    logic [31:0] rf [8];
    logic [1:0]  rf_cmd;
    logic [7:0]  en_w;
    assign en_w   = {RfRegSel, RfScrSel};
    assign RfOutA = rf[RfOutASel];

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0: return 32'h1111_1111;
            1: return 32'h2222_0002;
            2: return 32'h3333_0003;
            3: return 32'h4444_0004;
            4: return 32'h5555_0005;
            5: return 32'h6666_0006;
            6: return 32'h7777_0007;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge Clock) begin
        for (int i = 0; i < 8; i++) begin
            if (rf_cmd == 2'd1) rf[i] <= init_val(i);
            else if (rf_cmd == 2'd2) rf[i] <= 32'h0;
            else if (RfFunSel == 3'b010 && en_w[7-i]) rf[i] <= RfI;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_rf [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              op;
        logic [7:0]        mask;
        bit                toggle;
        int                rst_after;
        int                exp_lat;
        logic [7:0][31:0]  words;
    } vec_t;

    function automatic vec_t mk(input logic op, input logic [7:0] mask, input bit toggle,
                                input int rst_after, input int exp_lat);
        vec_t v;
        v.op = op; v.mask = mask; v.toggle = toggle;
        v.rst_after = rst_after; v.exp_lat = exp_lat; v.words = '0;
        return v;
    endfunction

    task automatic check_file(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_rf%0d", tag, i), rf[i], exp_rf[i]);
    endtask

    // Issue one command, drive/consume its stream, and check latency, order, data and enables.
    task automatic run_vec(input vec_t v, output logic [7:0][31:0] cap);
        int idx_list [8];
        int k = 0, n = 1, widx = 0, nacc = 0, nwr = 0;
        bit got_done = 0, rst_hit = 0, stall_phase = 0, prev_hold = 0, saw_sv = 0, saw_rr = 0;
        logic [31:0] prev_d = '0;
        logic [2:0]  prev_i = '0;
        cap = '0;
        for (int i = 0; i < 8; i++) if (v.mask[i]) begin idx_list[k] = i; k++; end
        check("cmdready_idle", {31'd0, CmdReady}, 32'd1);
        CmdValid = 1'b1; CmdOp = v.op; CmdMask = v.mask;
        SaveReady = v.toggle ? 1'b0 : 1'b1; RestValid = 1'b0;
        @(negedge Clock);
        CmdValid = 1'b0;
        while (n <= 200) begin
            if (Done) begin
                got_done = 1;
                check("done_lat", n, v.exp_lat);
                check("done_cmdready", {31'd0, CmdReady}, 32'd0);
                break;
            end
            if (n == 1) check("busy", {31'd0, Busy}, 32'd1);
            if (SaveValid) saw_sv = 1;
            if (RestReady) saw_rr = 1;
            if (en_w != 8'h00) begin
                if (!v.op) check("save_we", en_w, 32'h0);
                else if (nwr >= k) check("rest_we_extra", nwr, k - 1);
                else check("rest_we", en_w, 8'h80 >> idx_list[nwr]);
                nwr++;
            end
            if (!v.op) begin
                if (SaveValid) begin
                    if (prev_hold) begin
                        check("stall_data", SaveData, prev_d);
                        check("stall_idx", SaveIdx, prev_i);
                    end
                    if (v.toggle) begin SaveReady = stall_phase; stall_phase = ~stall_phase; end
                    if (SaveReady) begin
                        if (widx < k) begin
                            check("save_idx", SaveIdx, idx_list[widx]);
                            check("save_data", SaveData, exp_rf[idx_list[widx]]);
                            cap[widx] = SaveData;
                        end else check("save_extra", widx, k - 1);
                        widx++;
                    end
                    prev_hold = !SaveReady; prev_d = SaveData; prev_i = SaveIdx;
                end else begin
                    prev_hold = 0;
                    if (v.toggle) SaveReady = 1'b0;
                end
            end else begin
                RestData  = v.words[nacc[2:0]];
                RestValid = (nacc < k);
                if (v.rst_after >= 0 && nacc == v.rst_after && RestReady) begin
                    Reset = 1'b1; RestValid = 1'b0;
                    @(negedge Clock);
                    Reset = 1'b0;
                    check("rst_cmdready", {31'd0, CmdReady}, 32'd1);
                    check("rst_busy", {31'd0, Busy}, 32'd0);
                    check("rst_done", {31'd0, Done}, 32'd0);
                    check("rst_we", en_w, 32'h0);
                    rst_hit = 1;
                    break;
                end
                if (RestReady && RestValid) begin
                    exp_rf[idx_list[nacc]] = v.words[nacc[2:0]];
                    nacc++;
                end
            end
            @(negedge Clock);
            n++;
        end
        RestValid = 1'b0; SaveReady = 1'b1;
        if (v.exp_lat < 0) check("done_unexpected", {31'd0, got_done}, 32'd0);
        else if (!got_done) check("done_timeout", n, v.exp_lat);
        if (!rst_hit) begin
            if (!v.op) check("save_count", widx, k);
            else check("write_count", nwr, k);
        end
        if (!v.op) check("save_no_restready", {31'd0, saw_rr}, 32'd0);
        else check("rest_no_savevalid", {31'd0, saw_sv}, 32'd0);
        if (v.mask == 8'h00) check("empty_no_stream", {30'd0, saw_sv, saw_rr}, 32'd0);
        @(negedge Clock);
        check("after_cmdready", {31'd0, CmdReady}, 32'd1);
        check("after_done", {31'd0, Done}, 32'd0);
        check_file("file");
    endtask

    vec_t tbl [6];
    logic [7:0][31:0] cap;
    logic [31:0] orig [8];
    vec_t rt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = mk(1'b0, 8'h81, 1'b0, -1, 5);
        tbl[1] = mk(1'b1, 8'h12, 1'b0, -1, 5);
        tbl[1].words[0] = 32'hA5A5_0001;
        tbl[1].words[1] = 32'h0000_00FF;
        tbl[2] = mk(1'b0, 8'hFF, 1'b1, -1, 25);
        tbl[3] = mk(1'b0, 8'h00, 1'b0, -1, 1);
        tbl[4] = mk(1'b1, 8'h00, 1'b0, -1, 1);
        tbl[5] = mk(1'b1, 8'h0F, 1'b0, 2, -1);
        tbl[5].words[0] = 32'hC0DE_0001;
        tbl[5].words[1] = 32'hC0DE_0002;
        tbl[5].words[2] = 32'hC0DE_0003;
        tbl[5].words[3] = 32'hC0DE_0004;

        Reset = 1'b1; rf_cmd = 2'd1;
        CmdValid = 1'b0; CmdOp = 1'b0; CmdMask = 8'h00;
        SaveReady = 1'b1; RestData = 32'h0; RestValid = 1'b0;
        for (int i = 0; i < 8; i++) exp_rf[i] = init_val(i);
        repeat (2) @(negedge Clock);
        Reset = 1'b0; rf_cmd = 2'd0;
        check("reset_cmdready", {31'd0, CmdReady}, 32'd1);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_savevalid", {31'd0, SaveValid}, 32'd0);
        check("reset_restready", {31'd0, RestReady}, 32'd0);
        check("reset_we", en_w, 32'h0);
        check("reset_outasel", RfOutASel, 32'h0);
        check("reset_rfi", RfI, 32'h0);
        check("reset_savedata", SaveData, 32'h0);
        check("reset_saveidx", SaveIdx, 32'h0);
        check("funsel", RfFunSel, 32'h2);
        @(negedge Clock);

        for (int v = 0; v < 6; v++) run_vec(tbl[v], cap);

        // Round trip: capture everything, wipe the file, restore the captured stream.
        for (int i = 0; i < 8; i++) orig[i] = exp_rf[i];
        run_vec(mk(1'b0, 8'hFF, 1'b0, -1, 17), cap);
        rf_cmd = 2'd2;
        @(negedge Clock);
        rf_cmd = 2'd0;
        for (int i = 0; i < 8; i++) exp_rf[i] = 32'h0;
        rt = mk(1'b1, 8'hFF, 1'b0, -1, 17);
        rt.words = cap;
        run_vec(rt, cap);
        for (int i = 0; i < 8; i++) check($sformatf("roundtrip_rf%0d", i), rf[i], orig[i]);
        check("funsel_end", RfFunSel, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
